// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Builds 32-bit MIPS machine words (nop, addu, subu, ori, lui, lw, sw, beq,
//   j, jal, jr) from field-level requests. Words are queued in a DEPTH-entry
//   FIFO and leave tagged with a sequential instruction-memory address that
//   starts at BASE_ADDR and advances by 4 on every pop.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     request present
//   in_ready     request can be accepted (FIFO not full)
//   in_kind      0 nop,1 addu,2 subu,3 ori,4 lui,5 lw,6 sw,7 beq,8 j,9 jal,10 jr
//   in_rs/rt/rd  register fields
//   in_imm       16-bit immediate / branch offset
//   in_target    26-bit jump index
//   out_valid    encoded word available at FIFO head
//   out_ready    consumer takes the head word
//   out_instr    head word (zero when empty)
//   out_addr     IM address of out_instr
//   count        FIFO occupancy, 0..DEPTH
//   err_illegal  one-cycle pulse after an illegal kind was accepted and dropped
module mips_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_kind,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [15:0]                in_imm,
  input  logic [25:0]                in_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Returns {legal, word}. Unused fields of each format are forced to zero.
  function automatic logic [32:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [32:0] r;
    r = '0;
    case (kind)
      4'd0:    r = {1'b1, 32'h0000_0000};
      4'd1:    r = {1'b1, 6'b000000, rs, rt, rd, 5'b0, 6'b100001};
      4'd2:    r = {1'b1, 6'b000000, rs, rt, rd, 5'b0, 6'b100011};
      4'd3:    r = {1'b1, 6'b001101, rs, rt, imm};
      4'd4:    r = {1'b1, 6'b001111, 5'b0, rt, imm};
      4'd5:    r = {1'b1, 6'b100011, rs, rt, imm};
      4'd6:    r = {1'b1, 6'b101011, rs, rt, imm};
      4'd7:    r = {1'b1, 6'b000100, rs, rt, imm};
      4'd8:    r = {1'b1, 6'b000010, target};
      4'd9:    r = {1'b1, 6'b000011, target};
      4'd10:   r = {1'b1, 6'b000000, rs, 15'b0, 6'b001000};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [31:0]      addr_q,   addr_d;
  logic             err_q,    err_d;

  logic [32:0]      enc;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;

  assign in_ready    = (count_q != CNT_W'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign out_instr   = out_valid ? mem[rd_ptr_q] : 32'h0;
  assign out_addr    = addr_q;
  assign count       = count_q;
  assign err_illegal = err_q;

  always_comb begin
    enc      = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
    legal    = enc[32];
    accept   = in_valid && in_ready;
    // Illegal kinds complete the handshake but never reach the FIFO.
    push     = accept && legal;
    pop      = out_valid && out_ready;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    addr_d   = pop  ? addr_q + 32'd4       : addr_q;
    err_d    = accept && !legal;

    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= enc[31:0];
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Inverse of the CPU's instruction decoder: turns field-level instruction requests into 32-bit MIPS machine words for the P4 instruction set (nop, addu, subu, ori, lui, lw, sw, beq, j, jal, jr). Encoded words are buffered in a small FIFO. They leave with a sequential instruction-memory address. The block feeds the IM loader and the self-checking testbench stimulus path, so programs can be generated on-chip instead of hand-assembled.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
BASE_ADDR, 32'h0000_3000, address assigned to the first word emitted after reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  request present
in_ready  output  1  request can be accepted this cycle
in_kind  input  4  0 nop, 1 addu, 2 subu, 3 ori, 4 lui, 5 lw, 6 sw, 7 beq, 8 j, 9 jal, 10 jr; 11-15 illegal
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field
in_imm  input  16  immediate / offset
in_target  input  26  jump target index
out_valid  output  1  encoded word available
out_ready  input  1  consumer takes word
out_instr  output  32  encoded word at FIFO head
out_addr  output  32  IM address of out_instr
count  output  clog2(DEPTH)+1  current FIFO occupancy
err_illegal  output  1  one-cycle pulse: an illegal kind was accepted and dropped

Behaviour:
- Reset: asynchronous, active-low. FIFO is flushed and count=0; out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, in_ready=1 (once reset is released). Asserting reset mid-transfer discards all buffered words and any in-flight request.
- Accept: an input handshake occurs when in_valid & in_ready at a rising edge. in_ready = (count != DEPTH). It is combinational from state only, never from in_valid or out_ready.
- Encoding is combinational on the request fields and is written into the FIFO tail on accept. Fields a format does not use are ignored and forced to zero:
  - nop = 32'h0000_0000
  - addu = {6'b000000, rs, rt, rd, 5'b0, 6'b100001}
  - subu = the addu format with func 6'b100011
  - ori = {6'b001101, rs, rt, imm}
  - lui = {6'b001111, 5'b0, rt, imm}
  - lw = {6'b100011, rs, rt, imm}
  - sw = {6'b101011, rs, rt, imm}
  - beq = {6'b000100, rs, rt, imm}
  - j = {6'b000010, target}
  - jal = {6'b000011, target}
  - jr = {6'b000000, rs, 15'b0, 6'b001000}
- Illegal kind (11-15): the request is accepted (handshake completes) but nothing is written to the FIFO and count is unchanged. err_illegal is high for exactly the cycle after the accepting edge.
- Latency: a word accepted at edge N is visible on out_instr with out_valid=1 after edge N, provided the FIFO was empty. There is no combinational path from input to output.
- Output: out_valid = (count != 0). out_instr is the FIFO head and stays stable while out_valid & !out_ready.
- Output handshake is out_valid & out_ready at an edge. It pops the head and sets out_addr += 4, wrapping mod 2^32. out_addr changes only on a pop.
- Simultaneous push and pop:
  - When not full, count is unchanged and both pointers advance.
  - When full, in_ready=0, so only the pop happens.
  - When empty, no pop occurs because out_valid=0, so only the push happens.
- Pointers wrap modulo DEPTH. count is never greater than DEPTH and never negative.

Test Plan:
- Reset release, then push kind=1 (addu) rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_instr=32'h0022_1821, out_addr=32'h0000_3000. Pop, then push ori rs=0 rt=5 imm=16'h1234 -> out_instr=32'h3405_1234, out_addr=32'h0000_3004.
- Push lui rt=8 imm=16'hFFFF, beq rs=1 rt=2 imm=16'hFFFD, jal target=26'h0000C03, jr rs=31 with out_ready=0 -> words 32'h3C08_FFFF, 32'h1022_FFFD, 32'h0C00_0C03, 32'h03E0_0008 are stored; count=4, in_ready=0. A fifth in_valid is not accepted.
- Full FIFO with in_valid=1 and out_ready=1 -> one pop per cycle; in_ready returns to 1 after the first pop. Order is preserved and addresses increment by 4.
- Push kind=13 -> accepted, err_illegal high for one cycle, count unchanged, out_addr unchanged. Then push nop -> out_instr=32'h0000_0000.
- Fill 3 entries, then pull reset low mid-stream -> out_valid=0, count=0 and out_addr=BASE_ADDR immediately, without waiting for a clock edge.
- Streaming with in_valid=1 and out_ready=1 continuously -> throughput of one word per cycle, count stays at 1, no word is lost or duplicated over 20 requests.
